// File: rtl/output_packer.sv
// ----------------------------------------------------------------------------
// output_packer
//
// Byte-serial to parallel packer. Bytes arrive one per valid/ready handshake
// and are packed into a [0:8*n-1] vector, first byte in the leftmost slot.
// The vector is presented on a valid/ack handshake once n bytes have arrived,
// or earlier when flush closes a partial vector. Unfilled slots read 0 and
// out_len reports how many leading bytes are valid.
//
// Parameters:
//   n          bytes per packed vector (n >= 1)
//   CW         width of the byte count, derived as $clog2(n+1)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   byte offered on in_data
//   in_data    offered byte
//   in_ready   byte accepted this cycle when in_valid is also high
//   flush      close the current partial vector early
//   out_vec    packed vector; k-th accepted byte at out_vec[8*k +: 8]
//   out_len    number of valid bytes in out_vec (1..n)
//   out_valid  out_vec/out_len valid and held until out_ack
//   out_ack    consumer takes the vector when out_valid is high
// ----------------------------------------------------------------------------
module output_packer #(
    parameter  int n  = 2,
    localparam int CW = $clog2(n + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            flush,
    output logic [0:8*n-1]  out_vec,
    output logic [CW-1:0]   out_len,
    output logic            out_valid,
    input  logic            out_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [0:8*n-1]   r_vec;
    logic [CW-1:0]    r_len;
    logic             r_valid;
    logic             r_ready;

    logic             w_accept;
    logic [CW-1:0]    w_count_next;
    logic             w_close;

    // r_ready is only ever high in FILL, so it doubles as the state qualifier.
    assign w_accept     = in_valid && r_ready;
    assign w_count_next = r_count + CW'(w_accept);

    // Close on the n-th byte, or on flush when at least one byte (possibly the
    // one arriving this cycle) is in the vector. A flush that lands on the
    // n-th byte yields the same length n as a normal completion.
    assign w_close = (r_state == S_FILL) &&
                     ((w_accept && (r_count == CW'(n - 1))) ||
                      (flush && (w_count_next != '0)));

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            // NOTE: the data vector is reset too, since unreceived slots
            // must read 0 and partial data must never leak past a reset.
            r_vec   <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FILL;
                    r_ready <= 1'b1;
                end

                S_FILL: begin
                    if (w_accept) begin
                        // Decode the slot with constant selects so each byte
                        // lane is a plain enable-register.
                        for (int k = 0; k < n; k++) begin
                            if (r_count == CW'(k)) begin
                                r_vec[8*k +: 8] <= in_data;
                            end
                        end
                        r_count <= w_count_next;
                    end
                    if (w_close) begin
                        r_state <= S_HOLD;
                        r_len   <= w_count_next;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (out_ack) begin
                        r_state <= S_FILL;
                        r_valid <= 1'b0;
                        r_vec   <= '0;
                        r_count <= '0;
                        r_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign out_vec   = r_vec;
    assign out_len   = r_len;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_output_packer.sv
// ----------------------------------------------------------------------------
// tb_output_packer
//
// Two instances: dut2 (n=2) for reset/fill and stall sequences, dut4 (n=4)
// for a table of packed vectors, flush cases and mid-operation reset.
// dut4 results are checked through a scoreboard queue: expected vectors are
// pushed when stimulus is driven and popped when the DUT hands one off.
// ----------------------------------------------------------------------------
module tb_output_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- n = 2 instance ----------------
    logic        rst2_n, v2, f2, a2;
    logic [7:0]  d2;
    logic        rdy2, ov2;
    logic [0:15] vec2;
    logic [1:0]  len2;

    output_packer #(.n(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .in_valid  (v2),
        .in_data   (d2),
        .in_ready  (rdy2),
        .flush     (f2),
        .out_vec   (vec2),
        .out_len   (len2),
        .out_valid (ov2),
        .out_ack   (a2)
    );

    // ---------------- n = 4 instance ----------------
    logic        rst4_n, v4, f4, a4;
    logic [7:0]  d4;
    logic        rdy4, ov4;
    logic [0:31] vec4;
    logic [2:0]  len4;

    output_packer #(.n(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .in_valid  (v4),
        .in_data   (d4),
        .in_ready  (rdy4),
        .flush     (f4),
        .out_vec   (vec4),
        .out_len   (len4),
        .out_valid (ov4),
        .out_ack   (a4)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for dut4 ----------------
    typedef struct {
        logic [31:0] vec;
        logic [2:0]  len;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (rst4_n && ov4 && a4) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_vec", 64'(vec4), 64'(e.vec));
                check("sb_len", 64'(len4), 64'(e.len));
            end
        end
    end

    // Offer nb bytes (MSB-first in 'bytes') to dut4, each held until accepted.
    // Flush is raised together with the last byte when fl is set.
    // in_valid is left as-is at the end so callers can chain vectors.
    task automatic feed4(input logic [31:0] bytes, input int nb, input bit fl);
        logic [31:0] sh;
        for (int i = 0; i < nb; i++) begin
            int guard;
            guard = 0;
            sh = bytes << (8 * i);
            v4 = 1'b1;
            d4 = sh[31:24];
            f4 = fl && (i == nb - 1);
            @(negedge clk);
            while (!rdy4 && guard < 50) begin
                guard++;
                @(negedge clk);
            end
            if (!rdy4) check("feed4_timeout", 64'(rdy4), 64'd1);
            tick();
        end
        f4 = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        int          nb;
        logic [31:0] bytes;
        bit          fl;
        logic [31:0] ev;
        logic [2:0]  el;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Table for dut4, fed back-to-back with out_ack held high.
        tbl[0] = '{4, 32'h01020304, 1'b0, 32'h01020304, 3'd4};
        tbl[1] = '{4, 32'h05060708, 1'b0, 32'h05060708, 3'd4};
        tbl[2] = '{2, 32'h11220000, 1'b1, 32'h11220000, 3'd2};
        tbl[3] = '{1, 32'h9A000000, 1'b1, 32'h9A000000, 3'd1};
        tbl[4] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 3'd4};
        tbl[5] = '{3, 32'hC0FFEE00, 1'b1, 32'hC0FFEE00, 3'd3};

        rst2_n = 1'b0; v2 = 1'b0; f2 = 1'b0; a2 = 1'b0; d2 = 8'h00;
        rst4_n = 1'b0; v4 = 1'b0; f4 = 1'b0; a4 = 1'b0; d4 = 8'h00;

        // ---------- n=2: reset then fill ----------
        tick();
        check("rst_vec2", 64'(vec2), 64'd0);
        check("rst_len2", 64'(len2), 64'd0);
        check("rst_ov2",  64'(ov2),  64'd0);
        check("rst_rdy2", 64'(rdy2), 64'd0);
        tick();
        check("rst_rdy2_b", 64'(rdy2), 64'd0);
        rst2_n = 1'b1;
        tick();
        check("rdy_after_release", 64'(rdy2), 64'd1);
        v2 = 1'b1; d2 = 8'hA5;
        tick();
        d2 = 8'h3C;
        tick();
        v2 = 1'b0; d2 = 8'h00;
        check("fill_vec2", 64'(vec2), 64'hA53C);
        check("fill_len2", 64'(len2), 64'd2);
        check("fill_ov2",  64'(ov2),  64'd1);
        check("fill_rdy2", 64'(rdy2), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_vec2", 64'(vec2), 64'hA53C);
            check("hold_ov2",  64'(ov2),  64'd1);
        end
        a2 = 1'b1;
        tick();
        a2 = 1'b0;
        check("ack_vec2", 64'(vec2), 64'd0);
        check("ack_ov2",  64'(ov2),  64'd0);
        check("ack_rdy2", 64'(rdy2), 64'd1);

        // ---------- n=2: stall ----------
        v2 = 1'b1; d2 = 8'h7E;
        tick();
        v2 = 1'b0; d2 = 8'h55;
        tick();
        tick();
        v2 = 1'b1; d2 = 8'h81;
        tick();
        check("stall_vec2", 64'(vec2), 64'h7E81);
        check("stall_len2", 64'(len2), 64'd2);
        check("stall_ov2",  64'(ov2),  64'd1);
        // Byte offered during HOLD and in the ack cycle must stay pending.
        d2 = 8'h99;
        tick();
        tick();
        check("holdin_vec2", 64'(vec2), 64'h7E81);
        check("holdin_rdy2", 64'(rdy2), 64'd0);
        a2 = 1'b1;
        tick();
        a2 = 1'b0;
        check("gap_rdy2", 64'(rdy2), 64'd1);
        check("gap_vec2", 64'(vec2), 64'd0);
        tick();
        d2 = 8'h42;
        tick();
        v2 = 1'b0;
        check("after_gap_vec2", 64'(vec2), 64'h9942);
        check("after_gap_len2", 64'(len2), 64'd2);

        // ---------- n=4: table, back-to-back with immediate ack ----------
        rst4_n = 1'b1;
        tick();
        check("rdy4_start", 64'(rdy4), 64'd1);
        a4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.vec = tbl[i].ev;
            e.len = tbl[i].el;
            sb.push_back(e);
            feed4(tbl[i].bytes, tbl[i].nb, tbl[i].fl);
        end
        v4 = 1'b0;
        drain();

        // ---------- n=4: flush on empty ----------
        @(negedge clk);
        check("empty_rdy4_pre", 64'(rdy4), 64'd1);
        tick();
        f4 = 1'b1;
        tick();
        f4 = 1'b0;
        check("empty_ov4",  64'(ov4),  64'd0);
        check("empty_rdy4", 64'(rdy4), 64'd1);
        tick();
        check("empty_ov4_b", 64'(ov4), 64'd0);
        begin
            exp_t e;
            e.vec = 32'hCAFEF00D;
            e.len = 3'd4;
            sb.push_back(e);
        end
        feed4(32'hCAFEF00D, 4, 1'b0);
        v4 = 1'b0;
        drain();

        // ---------- n=4: reset mid-fill and in HOLD ----------
        a4 = 1'b0;
        tick();
        feed4(32'hAABB0000, 2, 1'b0);
        v4 = 1'b0;
        rst4_n = 1'b0;
        tick();
        check("midrst_vec4", 64'(vec4), 64'd0);
        check("midrst_len4", 64'(len4), 64'd0);
        check("midrst_ov4",  64'(ov4),  64'd0);
        check("midrst_rdy4", 64'(rdy4), 64'd0);
        rst4_n = 1'b1;
        tick();
        check("midrst_rdy4_back", 64'(rdy4), 64'd1);
        feed4(32'h10203040, 4, 1'b0);
        v4 = 1'b0;
        check("postrst_vec4", 64'(vec4), 64'h10203040);
        check("postrst_len4", 64'(len4), 64'd4);
        check("postrst_ov4",  64'(ov4),  64'd1);
        rst4_n = 1'b0;
        tick();
        check("holdrst_vec4", 64'(vec4), 64'd0);
        check("holdrst_len4", 64'(len4), 64'd0);
        check("holdrst_ov4",  64'(ov4),  64'd0);
        check("holdrst_rdy4", 64'(rdy4), 64'd0);
        rst4_n = 1'b1;
        tick();
        a4 = 1'b1;
        begin
            exp_t e;
            e.vec = 32'h0A0B0C0D;
            e.len = 3'd4;
            sb.push_back(e);
        end
        feed4(32'h0A0B0C0D, 4, 1'b0);
        v4 = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
